// File: rtl/csa_accumulator.sv
// ---------------------------------------------------------------------------
// csa_accumulator
//   Consumes {cout,sum} results from the 16-bit carry-select adder over a
//   valid/ready handshake and adds a programmed number of them into a wide
//   accumulator. The total and a sticky overflow flag are then offered over
//   a second valid/ready handshake.
//
//   Optional build macro: SATURATE_EN
//     defined   : an overflowing beat clamps the accumulator to all ones. It
//                 stays there for the rest of the job.
//     undefined : the accumulator wraps modulo 2^ACC_W. The overflow flag is
//                 set on the first wrap.
//
//   in_ready, out_valid, busy, out_acc and out_ovf are all flops. Each one
//   is loaded from the next-state value, so it always agrees with the FSM
//   state in the same cycle.
// ---------------------------------------------------------------------------
module csa_accumulator #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_ops,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_sum,
  input  logic              in_cout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_ovf,
  output logic              busy
);

  // FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};
  localparam logic [ACC_W-1:0] ACC_ONES = {ACC_W{1'b1}};

  // Widen an adder result {cout,sum} to the ACC_W+1 bit summing width.
  // ACC_W > DATA_W is guaranteed, so the zero pad is at least one bit wide.
  function automatic logic [ACC_W:0] zext_operand(input logic          cout,
                                                  input logic [DATA_W-1:0] sum);
    return {{(ACC_W-DATA_W){1'b0}}, cout, sum};
  endfunction

  // Core state
  logic [1:0]       state_r;
  logic [ACC_W-1:0] acc_r;
  logic             ovf_r;
  logic [CNT_W-1:0] remaining_r;

  // Next-state values
  logic [1:0]       state_nxt_s;
  logic [ACC_W-1:0] acc_nxt_s;
  logic             ovf_nxt_s;
  logic [CNT_W-1:0] remaining_nxt_s;

  // Datapath / handshake helpers
  logic [ACC_W:0]   sum_s;
  logic             beat_s;
  logic             last_beat_s;
  logic             out_hs_s;

  // Registered outputs
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;
  logic [ACC_W-1:0] out_acc_r;
  logic             out_ovf_r;

  // A beat needs both sides of the input handshake.
  // The top bit of the widened sum is the carry out of the accumulator.
  always_comb begin
    sum_s       = {1'b0, acc_r} + zext_operand(in_cout, in_sum);
    beat_s      = in_valid && in_ready_r;
    last_beat_s = beat_s && (remaining_r == CNT_ONE);
    out_hs_s    = out_valid_r && out_ready;
  end

  // Next-state and accumulator update logic
  always_comb begin
    state_nxt_s     = state_r;
    acc_nxt_s       = acc_r;
    ovf_nxt_s       = ovf_r;
    remaining_nxt_s = remaining_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          acc_nxt_s = ACC_ZERO;
          ovf_nxt_s = 1'b0;
          if (num_ops != CNT_ZERO) begin
            remaining_nxt_s = num_ops;
            state_nxt_s     = ST_ACC;
          end else begin
            remaining_nxt_s = CNT_ZERO;
            state_nxt_s     = ST_DONE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACC: begin
        if (beat_s) begin
          remaining_nxt_s = remaining_r - CNT_ONE;
          if (sum_s[ACC_W]) begin
            ovf_nxt_s = 1'b1;
`ifdef SATURATE_EN
            // Once clamped, every later beat overflows again (or adds zero),
            // so the accumulator stays at all ones without extra state.
            acc_nxt_s = ACC_ONES;
`else
            acc_nxt_s = sum_s[ACC_W-1:0];
`endif
          end else begin
            acc_nxt_s = sum_s[ACC_W-1:0];
          end
          if (last_beat_s) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_ACC;
          end
        end else begin
          state_nxt_s = ST_ACC;
        end
      end
      ST_DONE: begin
        if (out_hs_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s     = ST_IDLE;
        acc_nxt_s       = ACC_ZERO;
        ovf_nxt_s       = 1'b0;
        remaining_nxt_s = CNT_ZERO;
      end
    endcase
  end

  // Core FSM, accumulator and operand counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      acc_r       <= ACC_ZERO;
      ovf_r       <= 1'b0;
      remaining_r <= CNT_ZERO;
    end else begin
      state_r     <= state_nxt_s;
      acc_r       <= acc_nxt_s;
      ovf_r       <= ovf_nxt_s;
      remaining_r <= remaining_nxt_s;
    end
  end

  // Output flops. They are decoded from the next state, so they line up
  // with the core registers on every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      out_acc_r   <= ACC_ZERO;
      out_ovf_r   <= 1'b0;
    end else begin
      in_ready_r  <= (state_nxt_s == ST_ACC);
      out_valid_r <= (state_nxt_s == ST_DONE);
      busy_r      <= (state_nxt_s != ST_IDLE);
      out_acc_r   <= acc_nxt_s;
      out_ovf_r   <= ovf_nxt_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign out_acc   = out_acc_r;
  assign out_ovf   = out_ovf_r;

endmodule

// File: tb/tb_csa_accumulator.sv
// ---------------------------------------------------------------------------
// tb_csa_accumulator
//   Self-checking bench for csa_accumulator.
//
//   The reference keeps the job total as a plain 64-bit integer. From that
//   total it derives the expected wrapped or saturated value and the
//   overflow flag.
//
//   A compare process checks every output on every falling edge. Directed
//   scenarios add literal expectations that pin the model.
//
//   Inputs change 1 time unit after the falling edge. This keeps them away
//   from both the sampling edge and the DUT clock edge.
// ---------------------------------------------------------------------------
module tb_csa_accumulator;

  localparam int DATA_W = 16;
  localparam int ACC_W  = 24;
  localparam int CNT_W  = 8;
  localparam logic [63:0] MAXV = 64'h0000_0000_00FF_FFFF;

  logic              clk;
  logic              rst;
  logic              start;
  logic [CNT_W-1:0]  num_ops;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_sum;
  logic              in_cout;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_acc;
  logic              out_ovf;
  logic              busy;

  int checks;
  int errors;

  csa_accumulator #(.DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_ops   (num_ops),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_cout   (in_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural reference ----------------
  // mode: 0 waiting for a job, 1 collecting operands, 2 holding a result
  int          m_mode;
  int          m_left;
  logic [63:0] m_total;

  function automatic logic [63:0] exp_acc(input logic [63:0] t);
`ifdef SATURATE_EN
    return (t > MAXV) ? MAXV : t;
`else
    return t % (MAXV + 64'd1);
`endif
  endfunction

  function automatic logic [63:0] exp_ovf(input logic [63:0] t);
    return (t > MAXV) ? 64'd1 : 64'd0;
  endfunction

  // Reference update on each accepted event
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode  <= 0;
      m_left  <= 0;
      m_total <= 64'd0;
    end else begin
      case (m_mode)
        0: begin
          if (start) begin
            m_total <= 64'd0;
            if (num_ops != 8'd0) begin
              m_left <= int'(num_ops);
              m_mode <= 1;
            end else begin
              m_mode <= 2;
            end
          end
        end
        1: begin
          if (in_valid) begin
            m_total <= m_total + 64'(in_sum) + (in_cout ? 64'd65536 : 64'd0);
            m_left  <= m_left - 1;
            if (m_left == 1) m_mode <= 2;
          end
        end
        2: begin
          if (out_ready) m_mode <= 0;
        end
        default: m_mode <= 0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the reference
  always @(negedge clk) begin
    chk("in_ready",  64'(in_ready),  (m_mode == 1) ? 64'd1 : 64'd0);
    chk("out_valid", 64'(out_valid), (m_mode == 2) ? 64'd1 : 64'd0);
    chk("busy",      64'(busy),      (m_mode != 0) ? 64'd1 : 64'd0);
    chk("out_acc",   64'(out_acc),   exp_acc(m_total));
    chk("out_ovf",   64'(out_ovf),   exp_ovf(m_total));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic begin_job(input int n);
    start   = 1'b1;
    num_ops = CNT_W'(n);
    tick();
    start   = 1'b0;
  endtask

  task automatic beat(input int s, input bit c);
    in_valid = 1'b1;
    in_sum   = DATA_W'(s);
    in_cout  = c;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic finish_job();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_after_hs_busy",  64'(busy),      64'd0);
    chk("idle_after_hs_valid", 64'(out_valid), 64'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    start     = 1'b0;
    num_ops   = 8'd0;
    in_valid  = 1'b0;
    in_sum    = 16'd0;
    in_cout   = 1'b0;
    out_ready = 1'b0;
    repeat (2) tick();
    chk("reset_out_acc",   64'(out_acc),   64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_busy",      64'(busy),      64'd0);
    rst = 1'b0;
    tick();

    // 1: reset while collecting, then a clean single-operand job
    begin_job(3);
    beat(50, 1'b0);
    chk("mid_job_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    repeat (2) tick();
    chk("rst_acc",      64'(out_acc),   64'd0);
    chk("rst_ovf",      64'(out_ovf),   64'd0);
    chk("rst_valid",    64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready),  64'd0);
    chk("rst_busy",     64'(busy),      64'd0);
    rst = 1'b0;
    tick();
    begin_job(1);
    beat(7, 1'b0);
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_acc",   64'(out_acc),   64'd7);
    finish_job();

    // 2: three operands including a carry-out; latency of out_valid
    begin_job(3);
    beat(100, 1'b0);
    beat(16'hFFFF, 1'b1);
    chk("three_pre_valid", 64'(out_valid), 64'd0);
    beat(5, 1'b0);
    chk("three_valid", 64'(out_valid), 64'd1);
    chk("three_acc",   64'(out_acc),   64'd131176);
    chk("three_ovf",   64'(out_ovf),   64'd0);
    finish_job();

    // 3: result held under backpressure, start ignored while pending
    begin_job(1);
    beat(9, 1'b0);
    for (int i = 0; i < 5; i++) begin
      start   = (i == 2);
      num_ops = 8'd5;
      tick();
      start = 1'b0;
      chk("hold_valid",    64'(out_valid), 64'd1);
      chk("hold_acc",      64'(out_acc),   64'd9);
      chk("hold_busy",     64'(busy),      64'd1);
      chk("hold_in_ready", 64'(in_ready),  64'd0);
    end
    finish_job();

    // 4: gaps in in_valid; only completed beats count
    begin_job(2);
    beat(3, 1'b0);
    in_sum = 16'd1000;
    tick();
    tick();
    chk("gap_not_done", 64'(out_valid), 64'd0);
    beat(11, 1'b0);
    chk("gap_done", 64'(out_valid), 64'd1);
    chk("gap_acc",  64'(out_acc),   64'd14);
    finish_job();

    // 5: overflow over 200 maximal operands
    begin_job(200);
    for (int i = 0; i < 200; i++) beat(16'hFFFF, 1'b1);
    chk("ovf_valid", 64'(out_valid), 64'd1);
`ifdef SATURATE_EN
    chk("ovf_acc", 64'(out_acc), 64'hFF_FFFF);
`else
    chk("ovf_acc", 64'(out_acc), 64'd9436984);
`endif
    chk("ovf_flag", 64'(out_ovf), 64'd1);
    finish_job();

    // 6: zero-operand job goes straight to a cleared result
    begin_job(0);
    chk("zero_valid", 64'(out_valid), 64'd1);
    chk("zero_acc",   64'(out_acc),   64'd0);
    chk("zero_ovf",   64'(out_ovf),   64'd0);
    finish_job();

    // Randomized traffic, checked cycle by cycle against the reference
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 399) == 0);
      start     = ($urandom_range(0, 3) == 0);
      num_ops   = CNT_W'($urandom_range(0, 5));
      in_valid  = ($urandom_range(0, 2) != 0);
      in_sum    = DATA_W'($urandom);
      in_cout   = $urandom_range(0, 1) == 1;
      out_ready = ($urandom_range(0, 2) == 0);
      tick();
    end
    rst       = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
